// File: rtl/flag_stack_register_pkg.sv
// Flag bit positions and the shared flag word type for the status register.
package procco_flag_pkg;
   localparam int FLAG_W = 4;
   localparam int FLAG_C = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 2;
   localparam int FLAG_V = 3;

   typedef logic [FLAG_W-1:0] flags_t;
endpackage

// File: rtl/flag_lifo.sv
// LIFO of saved flag words with count, full/empty and single-cycle error events.
module flag_lifo
   import procco_flag_pkg::*;
#(
   parameter int W     = 4,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic [W-1:0]                 wdata_i,
   output logic [W-1:0]                 top_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic                         pop_ok_o,
   output logic                         ovf_o,
   output logic                         unf_o
);
   localparam int CW = $clog2(DEPTH+1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] top_idx, wr_idx;
   logic          do_push, swap, wr_en;

   assign full_o   = (count_q == CW'(DEPTH));
   assign empty_o  = (count_q == '0);
   assign top_idx  = AW'(count_q - CW'(1));

   // A pop on a non-empty stack wins; a simultaneous push turns it into a swap.
   assign pop_ok_o = pop_i & ~empty_o;
   assign swap     = pop_ok_o & push_i;
   assign do_push  = push_i & ~pop_i & ~full_o;
   assign ovf_o    = push_i & ~pop_i & full_o;
   assign unf_o    = pop_i & empty_o;

   assign wr_en    = do_push | swap;
   assign wr_idx   = swap ? top_idx : AW'(count_q);
   assign top_o    = empty_o ? '0 : mem_q[top_idx];
   assign count_o  = count_q;

   always_comb begin
      count_d = count_q;
      if (do_push)
         count_d = count_q + CW'(1);
      else if (pop_ok_o && !push_i)
         count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   // Storage carries no reset; an empty count makes its contents irrelevant.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_idx] <= wdata_i;
   end
endmodule

// File: rtl/flag_stack_register.sv
// Live status flags with masked ALU update, save/restore stack and sticky stack errors.
module flag_stack_register
   import procco_flag_pkg::*;
#(
   parameter int                FLAG_W      = procco_flag_pkg::FLAG_W,
   parameter int                STACK_DEPTH = 4,
   parameter logic [FLAG_W-1:0] RESET_FLAGS = '0
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               FR_read,
   input  logic [FLAG_W-1:0]                  flag_mask,
   input  logic [FLAG_W-1:0]                  flag_in,
   input  logic                               push,
   input  logic                               pop,
   input  logic                               err_clear,
   output logic [FLAG_W-1:0]                  flags_out,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_count,
   output logic                               stack_full,
   output logic                               stack_empty,
   output logic                               overflow_err,
   output logic                               underflow_err
);
   logic [FLAG_W-1:0] flags_q, flags_d, top;
   logic              ovf_q, ovf_d, unf_q, unf_d;
   logic              pop_ok, ovf_ev, unf_ev;

   flag_lifo #(.W(FLAG_W), .DEPTH(STACK_DEPTH)) u_lifo (
      .clk      (clk),
      .rst      (reset),
      .push_i   (push),
      .pop_i    (pop),
      .wdata_i  (flags_q),
      .top_o    (top),
      .count_o  (stack_count),
      .full_o   (stack_full),
      .empty_o  (stack_empty),
      .pop_ok_o (pop_ok),
      .ovf_o    (ovf_ev),
      .unf_o    (unf_ev)
   );

   always_comb begin
      flags_d = flags_q;
      if (pop_ok)
         flags_d = top;
      else if (FR_read)
         flags_d = (flags_q & ~flag_mask) | (flag_in & flag_mask);
      // A new error event overrides a same-cycle clear.
      ovf_d = ovf_ev | (ovf_q & ~err_clear);
      unf_d = unf_ev | (unf_q & ~err_clear);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags_q <= RESET_FLAGS;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         flags_q <= flags_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign flags_out     = flags_q;
   assign overflow_err  = ovf_q;
   assign underflow_err = unf_q;
endmodule

// File: tb/tb_flag_stack_register.sv
// Directed scenarios plus randomized traffic checked against a queue-based flag/stack model.
module tb_flag_stack_register;
   localparam int W = 4;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         FR_read = 1'b0, push = 1'b0, pop = 1'b0, err_clear = 1'b0;
   logic [W-1:0] flag_mask = '0, flag_in = '0;
   logic [W-1:0] flags_out;
   logic [2:0]   stack_count;
   logic         stack_full, stack_empty, overflow_err, underflow_err;

   int checks = 0;
   int failures = 0;

   logic [W-1:0] m_flags;
   logic [W-1:0] m_stk [$];
   bit           m_ovf, m_unf;

   flag_stack_register #(.FLAG_W(W), .STACK_DEPTH(D), .RESET_FLAGS('0)) dut (
      .clk(clk), .reset(reset), .FR_read(FR_read), .flag_mask(flag_mask), .flag_in(flag_in),
      .push(push), .pop(pop), .err_clear(err_clear), .flags_out(flags_out),
      .stack_count(stack_count), .stack_full(stack_full), .stack_empty(stack_empty),
      .overflow_err(overflow_err), .underflow_err(underflow_err)
   );

   always #5 clk = ~clk;

   function automatic logic [10:0] got_vec();
      return {flags_out, stack_count, stack_full, stack_empty, overflow_err, underflow_err};
   endfunction

   function automatic logic [10:0] exp_vec();
      int n = m_stk.size();
      return {m_flags, 3'(n), (n == D), (n == 0), m_ovf, m_unf};
   endfunction

   task automatic model_reset();
      m_flags = '0;
      m_stk.delete();
      m_ovf = 0;
      m_unf = 0;
   endtask

   // Model one clock edge from the architectural rules.
   task automatic model_step(input logic p, input logic po, input logic fr,
                             input logic [W-1:0] m, input logic [W-1:0] din, input logic clr);
      bit ev_o, ev_u;
      logic [W-1:0] t;
      ev_u = po && m_stk.size() == 0;
      ev_o = p && !po && m_stk.size() == D;
      if (po && m_stk.size() > 0) begin
         t = m_stk[m_stk.size()-1];
         if (p) m_stk[m_stk.size()-1] = m_flags;
         else   void'(m_stk.pop_back());
         m_flags = t;
      end else begin
         if (p && !po && m_stk.size() < D) m_stk.push_back(m_flags);
         if (fr) m_flags = (m_flags & ~m) | (din & m);
      end
      m_ovf = ev_o || (m_ovf && !clr);
      m_unf = ev_u || (m_unf && !clr);
   endtask

   task automatic cyc(input logic p, input logic po, input logic fr,
                      input logic [W-1:0] m, input logic [W-1:0] din, input logic clr);
      push = p; pop = po; FR_read = fr; flag_mask = m; flag_in = din; err_clear = clr;
      @(posedge clk);
      model_step(p, po, fr, m, din, clr);
      #1;
   endtask

   task automatic do_reset();
      push = 0; pop = 0; FR_read = 0; flag_mask = '0; flag_in = '0; err_clear = 0;
      reset = 1;
      @(posedge clk);
      #1 reset = 0;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      cyc(1, 0, 1, 4'hF, 4'h3, 0);
      cyc(1, 0, 1, 4'hF, 4'hA, 0);
      cyc(0, 0, 0, 4'h0, 4'h0, 0);
      checks++;
      if (got_vec() !== exp_vec() || flags_out !== 4'b1010 || stack_count !== 3'd2) begin
         failures++;
         $display("FAIL reset_setup got=%b exp=%b", got_vec(), exp_vec());
      end
      #3 reset = 1;
      #1;
      model_reset();
      checks++;
      if (got_vec() !== 11'b0000_000_0_1_0_0) begin
         failures++;
         $display("FAIL reset_async got=%b exp=%b", got_vec(), 11'b0000_000_0_1_0_0);
      end
      @(posedge clk);
      #1 reset = 0;
   endtask

   task automatic test_masked_write();
      do_reset();
      cyc(0, 0, 1, 4'b0011, 4'b1111, 0);
      checks++;
      if (flags_out !== 4'b0011) begin
         failures++;
         $display("FAIL masked_write got=%b exp=%b", flags_out, 4'b0011);
      end
      cyc(0, 0, 1, 4'b0000, 4'b1100, 0);
      checks++;
      if (flags_out !== 4'b0011) begin
         failures++;
         $display("FAIL masked_hold got=%b exp=%b", flags_out, 4'b0011);
      end
   endtask

   task automatic test_push_pop();
      do_reset();
      cyc(0, 0, 1, 4'hF, 4'b0101, 0);
      cyc(1, 0, 1, 4'hF, 4'b1010, 0);
      checks++;
      if (flags_out !== 4'b1010 || stack_count !== 3'd1) begin
         failures++;
         $display("FAIL push_fr got flags=%b cnt=%0d exp flags=1010 cnt=1", flags_out, stack_count);
      end
      cyc(0, 1, 1, 4'hF, 4'b1111, 0);
      checks++;
      if (flags_out !== 4'b0101 || stack_count !== 3'd0 || stack_empty !== 1'b1) begin
         failures++;
         $display("FAIL pop_fr got flags=%b cnt=%0d exp flags=0101 cnt=0", flags_out, stack_count);
      end
   endtask

   task automatic test_overflow();
      logic [W-1:0] e;
      do_reset();
      cyc(0, 0, 1, 4'hF, 4'd1, 0);
      for (int v = 2; v <= 5; v++)
         cyc(1, 0, 1, 4'hF, (v == 5) ? 4'hF : 4'(v), 0);
      checks++;
      if (stack_full !== 1'b1 || stack_count !== 3'd4 || overflow_err !== 1'b0) begin
         failures++;
         $display("FAIL fill got full=%b cnt=%0d ovf=%b exp full=1 cnt=4 ovf=0",
                  stack_full, stack_count, overflow_err);
      end
      cyc(1, 0, 0, 4'h0, 4'h0, 0);
      checks++;
      if (overflow_err !== 1'b1 || stack_count !== 3'd4 || flags_out !== 4'hF) begin
         failures++;
         $display("FAIL overflow got ovf=%b cnt=%0d flags=%h exp ovf=1 cnt=4 flags=f",
                  overflow_err, stack_count, flags_out);
      end
      for (int k = 0; k < 4; k++) begin
         cyc(0, 1, 0, 4'h0, 4'h0, 0);
         e = 4'(4 - k);
         checks++;
         if (flags_out !== e) begin
            failures++;
            $display("FAIL drain_%0d got=%h exp=%h", k, flags_out, e);
         end
      end
      checks++;
      if (stack_empty !== 1'b1 || overflow_err !== 1'b1) begin
         failures++;
         $display("FAIL drain_empty got empty=%b ovf=%b exp empty=1 ovf=1", stack_empty, overflow_err);
      end
   endtask

   task automatic test_underflow();
      do_reset();
      cyc(0, 1, 1, 4'hF, 4'b0110, 0);
      checks++;
      if (underflow_err !== 1'b1 || flags_out !== 4'b0110 || stack_count !== 3'd0) begin
         failures++;
         $display("FAIL underflow got unf=%b flags=%b exp unf=1 flags=0110", underflow_err, flags_out);
      end
      cyc(0, 0, 0, 4'h0, 4'h0, 1);
      checks++;
      if (underflow_err !== 1'b0) begin
         failures++;
         $display("FAIL err_clear got=%b exp=0", underflow_err);
      end
      cyc(0, 1, 0, 4'h0, 4'h0, 1);
      checks++;
      if (underflow_err !== 1'b1) begin
         failures++;
         $display("FAIL clear_vs_event got=%b exp=1", underflow_err);
      end
      cyc(1, 1, 1, 4'hF, 4'b1001, 0);
      checks++;
      if (flags_out !== 4'b1001 || stack_count !== 3'd0 || underflow_err !== 1'b1) begin
         failures++;
         $display("FAIL swap_empty got flags=%b cnt=%0d exp flags=1001 cnt=0", flags_out, stack_count);
      end
   endtask

   task automatic test_swap();
      do_reset();
      cyc(0, 0, 1, 4'hF, 4'b1100, 0);
      cyc(1, 0, 1, 4'hF, 4'b0011, 0);
      cyc(1, 1, 1, 4'hF, 4'b0110, 0);
      checks++;
      if (flags_out !== 4'b1100 || stack_count !== 3'd1) begin
         failures++;
         $display("FAIL swap got flags=%b cnt=%0d exp flags=1100 cnt=1", flags_out, stack_count);
      end
      cyc(0, 1, 0, 4'h0, 4'h0, 0);
      checks++;
      if (flags_out !== 4'b0011 || stack_empty !== 1'b1) begin
         failures++;
         $display("FAIL swap_top got flags=%b empty=%b exp flags=0011 empty=1", flags_out, stack_empty);
      end
   endtask

   task automatic test_random();
      logic p, po, fr, clr;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) < 2) begin
            #3 reset = 1;
            #1;
            model_reset();
            checks++;
            if (got_vec() !== exp_vec()) begin
               failures++;
               $display("FAIL rand_reset_%0d got=%b exp=%b", i, got_vec(), exp_vec());
            end
            @(posedge clk);
            #1 reset = 0;
         end
         p   = ($urandom_range(0, 99) < 40);
         po  = ($urandom_range(0, 99) < 35);
         fr  = ($urandom_range(0, 99) < 60);
         clr = ($urandom_range(0, 99) < 10);
         cyc(p, po, fr, 4'($urandom), 4'($urandom), clr);
         checks++;
         if (got_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL rand_%0d got=%b exp=%b", i, got_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_masked_write();
      test_push_pop();
      test_overflow();
      test_underflow();
      test_swap();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/flag_stack_register.md
Name: flag_stack_register

Overview:
- Parametrised processor status register holding FLAG_W condition flags.
- Supports per-flag masked update.
- Includes a LIFO shadow stack of depth STACK_DEPTH, so flags can be saved on interrupt/call entry and restored on return.
- Sits between the ALU flag outputs and the control unit / branch logic.
- Provides sticky stack-error reporting to the controller.

Parameters:
- FLAG_W, 4, number of flags; bit order is given by the package index constants.
- STACK_DEPTH, 4, number of saved flag words; must be >= 1.
- RESET_FLAGS, '0 (FLAG_W bits), value loaded into the live flags on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- FR_read  input  1  flag capture enable; when high, bits selected by flag_mask are loaded from flag_in.
- flag_mask  input  FLAG_W  per-flag update mask, qualified by FR_read.
- flag_in  input  FLAG_W  new flag values from the ALU.
- push  input  1  save the live flags onto the stack.
- pop  input  1  restore the live flags from the stack top.
- err_clear  input  1  clears the sticky error bits.
- flags_out  output  FLAG_W  live flag register.
- stack_count  output  $clog2(STACK_DEPTH+1)  number of valid stack entries.
- stack_full  output  1  stack_count == STACK_DEPTH (combinational from count).
- stack_empty  output  1  stack_count == 0 (combinational from count).
- overflow_err  output  1  sticky: push attempted while full.
- underflow_err  output  1  sticky: pop attempted while empty.

Behaviour:
- Reset, asynchronous and immediate:
  - flags_out = RESET_FLAGS.
  - stack_count = 0, stack_empty = 1, stack_full = 0.
  - overflow_err = underflow_err = 0.
  - Stack contents are don't-care and need no reset.
- Reset mid-operation discards all saved entries; there is no partial state.
- Live update: when FR_read = 1 and no effective pop, each bit i with flag_mask[i] = 1 takes flag_in[i] on the next edge. Unmasked bits hold. Latency is 1 cycle.
- Push, when not full and pop = 0:
  - The stack writes the pre-edge flags_out, i.e. the value before any same-cycle FR_read update, at index stack_count.
  - stack_count increments.
  - A same-cycle FR_read update still applies to the live flags.
- Push while full: stack and count are unchanged, overflow_err is set to 1, and FR_read still applies.
- Pop, when not empty and push = 0:
  - flags_out is loaded with the entry at index stack_count-1 and stack_count decrements.
  - Pop has priority over FR_read: the same-cycle flag write is dropped.
- Pop while empty: underflow_err is set to 1, count is unchanged, and FR_read still applies.
- Push and pop together (swap):
  - If not empty: the top entry is replaced by the pre-edge flags_out, flags_out is loaded with the old top entry, count is unchanged, and FR_read is dropped.
  - If empty: underflow_err is set to 1, nothing else changes from the stack, FR_read applies, and no entry is pushed.
- Errors:
  - overflow_err and underflow_err remain 1 until err_clear.
  - If err_clear and a new error event occur in the same cycle, the error wins (the bit remains/becomes 1).
- No combinational path from push/pop to flags_out; all outputs are registered or derived from registered count.

Decomposition:
- Package procco_flag_pkg holds:
  - Index constants FLAG_C = 0, FLAG_Z = 1, FLAG_N = 2, FLAG_V = 3.
  - Default FLAG_W = 4.
  - typedef flags_t as a packed logic vector [FLAG_W-1:0].
- One sub-module, flag_lifo, parametrised on width and depth. It owns:
  - the storage array;
  - the count;
  - the push/pop/swap;
  - full/empty and error detection.
- The top level owns the live register, mask merge, pop priority, and sticky error bits.

Test Plan (FLAG_W = 4, STACK_DEPTH = 4, RESET_FLAGS = 0):
- Reset mid-operation: assert reset asynchronously between edges with count = 2 and flags = 4'b1010 -> outputs go immediately to flags_out = 0, stack_count = 0, stack_empty = 1, errors = 0.
- Masked write: flags = 4'b0000, FR_read = 1, flag_mask = 4'b0011, flag_in = 4'b1111 -> flags_out = 4'b0011 one cycle later. Then mask = 0 -> flags_out holds 4'b0011.
- Push/pop round trip with overlapping FR_read:
  - With flags = 4'b0101: push and FR_read (mask = 4'b1111, flag_in = 4'b1010) together -> stack_count = 1, flags_out = 4'b1010.
  - Then pop and FR_read (flag_in = 4'b1111) together -> flags_out = 4'b0101 (write dropped), stack_count = 0.
- Full/overflow:
  - Push flags 1, 2, 3, 4 -> stack_full = 1.
  - A fifth push with flags = 4'b1111 -> overflow_err = 1, count = 4.
  - Then four pops -> flags_out = 4, 3, 2, 1 in turn, stack_empty = 1.
- Empty/underflow and clear:
  - Pop with count = 0 and FR_read flag_in = 4'b0110 -> underflow_err = 1, flags_out = 4'b0110.
  - err_clear alone -> underflow_err = 0.
  - err_clear together with another empty pop -> underflow_err stays 1.
- Swap: stack top = 4'b1100, count = 1, flags_out = 4'b0011; push and pop together -> flags_out = 4'b1100, top = 4'b0011, count = 1.
